// File: rtl/adpll_pkg.sv
// rtl/adpll_pkg.sv - shared types, widths and helpers for the error weighting controller
package adpll_pkg;

  localparam int ERR_W    = 8;
  localparam int WEIGHT_W = 3;

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_TRACK   = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  // Magnitude as unsigned; -128 maps to 128 since the result is read unsigned.
  function automatic logic [ERR_W-1:0] abs8(input logic [ERR_W-1:0] e);
    return e[ERR_W-1] ? (~e + 8'd1) : e;
  endfunction

  // weight = max(1, 7 - min(7, avg >> 2))
  function automatic logic [WEIGHT_W-1:0] calc_weight(input logic [ERR_W-1:0] avg);
    logic [5:0] q;
    logic [2:0] m;
    q = avg[7:2];
    m = (q > 6'd7) ? 3'd7 : q[2:0];
    return (m == 3'd7) ? 3'd1 : (3'd7 - m);
  endfunction

endpackage

// File: rtl/abs_accumulator.sv
// rtl/abs_accumulator.sv - per-channel |error| accumulator with window-end clear and average
module abs_accumulator
  import adpll_pkg::*;
#(
  parameter int WINDOW_LOG2 = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             sample_valid_i,
  input  logic             window_end_i,
  input  logic [ERR_W-1:0] error_i,
  output logic [ERR_W-1:0] avg_o
);

  localparam int ACC_W = ERR_W + WINDOW_LOG2;

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] sum_d;

  // The average includes the sample being accepted, so it is taken from the sum.
  assign sum_d = acc_q + ACC_W'(abs8(error_i));
  assign avg_o = sum_d[ACC_W-1:WINDOW_LOG2];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q <= '0;
    end else if (sample_valid_i) begin
      acc_q <= window_end_i ? '0 : sum_d;
    end
  end

endmodule

// File: rtl/error_weight_controller.sv
// rtl/error_weight_controller.sv - windowed error weighting with acquire/track/lock state machine
module error_weight_controller
  import adpll_pkg::*;
#(
  parameter int WINDOW_LOG2   = 4,
  parameter int LOCK_THRESH   = 4,
  parameter int LOCK_COUNT    = 32,
  parameter int UNLOCK_THRESH = 16,
  parameter int ACQ_THRESH    = 64
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                sample_valid_i,
  input  logic [ERR_W-1:0]    error_0_i,
  input  logic [ERR_W-1:0]    error_1_i,
  input  logic [ERR_W-1:0]    error_2_i,
  input  logic [ERR_W-1:0]    error_3_i,
  input  logic [ERR_W-1:0]    error_comb_i,
  output logic [WEIGHT_W-1:0] weight_0_o,
  output logic [WEIGHT_W-1:0] weight_1_o,
  output logic [WEIGHT_W-1:0] weight_2_o,
  output logic [WEIGHT_W-1:0] weight_3_o,
  output logic                lock_o,
  output logic [1:0]          state_o
);

  localparam int LC_W = $clog2(LOCK_COUNT + 1);
  localparam logic [LC_W-1:0]  LOCK_CNT_C   = LC_W'(LOCK_COUNT);
  localparam logic [ERR_W-1:0] LOCK_THR_C   = ERR_W'(LOCK_THRESH);
  localparam logic [ERR_W-1:0] UNLOCK_THR_C = ERR_W'(UNLOCK_THRESH);
  localparam logic [ERR_W-1:0] ACQ_THR_C    = ERR_W'(ACQ_THRESH);

  state_e                  state_q;
  logic                    lock_q;
  logic [WEIGHT_W-1:0]     weight_q [4];
  logic [LC_W-1:0]         lock_cnt_q;
  logic [WINDOW_LOG2-1:0]  win_cnt_q;

  logic [ERR_W-1:0] err_w [4];
  logic [ERR_W-1:0] avg_w [4];
  logic [ERR_W-1:0] abs_comb;
  logic             window_end;
  logic             any_acq;
  logic             comb_ok;
  logic             lock_hit;
  logic             all_lost;

  assign err_w[0] = error_0_i;
  assign err_w[1] = error_1_i;
  assign err_w[2] = error_2_i;
  assign err_w[3] = error_3_i;

  for (genvar g = 0; g < 4; g++) begin : g_acc
    abs_accumulator #(.WINDOW_LOG2(WINDOW_LOG2)) u_acc (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .sample_valid_i (sample_valid_i),
      .window_end_i   (window_end),
      .error_i        (err_w[g]),
      .avg_o          (avg_w[g])
    );
  end

  assign window_end = sample_valid_i && (&win_cnt_q);
  assign abs_comb   = abs8(error_comb_i);
  assign comb_ok    = (abs_comb <= LOCK_THR_C);
  assign lock_hit   = comb_ok && (lock_cnt_q == LOCK_CNT_C - 1'b1);
  assign all_lost   = window_end && !any_acq;

  always_comb begin
    any_acq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (avg_w[i] < ACQ_THR_C) any_acq = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_ACQUIRE;
      lock_q     <= 1'b0;
      lock_cnt_q <= '0;
      win_cnt_q  <= '0;
      for (int i = 0; i < 4; i++) weight_q[i] <= 3'd1;
    end else begin
      if (sample_valid_i) win_cnt_q <= win_cnt_q + 1'b1;
      case (state_q)
        ST_ACQUIRE: begin
          lock_cnt_q <= '0;
          if (sample_valid_i && window_end && any_acq) begin
            state_q <= ST_TRACK;
            for (int i = 0; i < 4; i++) weight_q[i] <= calc_weight(avg_w[i]);
          end
        end
        ST_TRACK: begin
          if (sample_valid_i) begin
            // Lock wins over loss of acquisition on the same edge.
            if (lock_hit) begin
              state_q    <= ST_LOCKED;
              lock_q     <= 1'b1;
              lock_cnt_q <= '0;
            end else if (all_lost) begin
              state_q    <= ST_ACQUIRE;
              lock_cnt_q <= '0;
            end else begin
              lock_cnt_q <= comb_ok ? (lock_cnt_q + 1'b1) : '0;
            end
            if (window_end) begin
              for (int i = 0; i < 4; i++) begin
                weight_q[i] <= (all_lost && !lock_hit) ? 3'd1 : calc_weight(avg_w[i]);
              end
            end
          end
        end
        ST_LOCKED: begin
          lock_cnt_q <= '0;
          if (sample_valid_i && (abs_comb > UNLOCK_THR_C)) begin
            state_q <= ST_TRACK;
            lock_q  <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_ACQUIRE;
          lock_q     <= 1'b0;
          lock_cnt_q <= '0;
          for (int i = 0; i < 4; i++) weight_q[i] <= 3'd1;
        end
      endcase
    end
  end

  assign weight_0_o = weight_q[0];
  assign weight_1_o = weight_q[1];
  assign weight_2_o = weight_q[2];
  assign weight_3_o = weight_q[3];
  assign lock_o     = lock_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_error_weight_controller.sv
// tb/tb_error_weight_controller.sv - directed and randomized bench with behavioural reference model
module tb_error_weight_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] e0 = '0, e1 = '0, e2 = '0, e3 = '0, ec = '0;
  logic [2:0] w0, w1, w2, w3;
  logic       lock;
  logic [1:0] state;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int m_state;
  int m_w [4];
  int m_sum [4];
  int m_cnt;
  int m_lc;

  always #5 clk = ~clk;

  error_weight_controller dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .sample_valid_i (valid),
    .error_0_i      (e0),
    .error_1_i      (e1),
    .error_2_i      (e2),
    .error_3_i      (e3),
    .error_comb_i   (ec),
    .weight_0_o     (w0),
    .weight_1_o     (w1),
    .weight_2_o     (w2),
    .weight_3_o     (w3),
    .lock_o         (lock),
    .state_o        (state)
  );

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int wt(input int avg);
    int q;
    int w;
    q = avg / 4;
    if (q > 7) q = 7;
    w = 7 - q;
    return (w < 1) ? 1 : w;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"}, {6'd0, state}, 8'(m_state));
    check({tag, ".lock"},  {7'd0, lock},  8'(m_state == 2));
    check({tag, ".w0"},    {5'd0, w0},    8'(m_w[0]));
    check({tag, ".w1"},    {5'd0, w1},    8'(m_w[1]));
    check({tag, ".w2"},    {5'd0, w2},    8'(m_w[2]));
    check({tag, ".w3"},    {5'd0, w3},    8'(m_w[3]));
  endtask

  task automatic model_reset();
    m_state = 0;
    m_cnt = 0;
    m_lc = 0;
    for (int i = 0; i < 4; i++) begin
      m_w[i] = 1;
      m_sum[i] = 0;
    end
  endtask

  // One accepted sample, expressed as window sums and plain state rules.
  task automatic model_step(input int a, input int b, input int c, input int d, input int comb);
    int e [4];
    int avg [4];
    bit wend, any_good, locked_now;
    e[0] = a; e[1] = b; e[2] = c; e[3] = d;
    for (int i = 0; i < 4; i++) m_sum[i] += iabs(e[i]);
    m_cnt++;
    wend = (m_cnt == 16);
    any_good = 0;
    for (int i = 0; i < 4; i++) begin
      avg[i] = m_sum[i] / 16;
      if (avg[i] < 64) any_good = 1;
    end
    locked_now = 0;
    case (m_state)
      0: if (wend && any_good) begin
        m_state = 1;
        for (int i = 0; i < 4; i++) m_w[i] = wt(avg[i]);
      end
      1: begin
        if (iabs(comb) <= 4) begin
          m_lc++;
          if (m_lc == 32) begin
            m_state = 2;
            locked_now = 1;
          end
        end else m_lc = 0;
        if (wend) begin
          if (!any_good && !locked_now) begin
            m_state = 0;
            for (int i = 0; i < 4; i++) m_w[i] = 1;
          end else begin
            for (int i = 0; i < 4; i++) m_w[i] = wt(avg[i]);
          end
        end
      end
      default: if (iabs(comb) > 16) m_state = 1;
    endcase
    if (m_state != 1) m_lc = 0;
    if (wend) begin
      m_cnt = 0;
      for (int i = 0; i < 4; i++) m_sum[i] = 0;
    end
  endtask

  task automatic garbage();
    e0 = 8'($urandom); e1 = 8'($urandom); e2 = 8'($urandom);
    e3 = 8'($urandom); ec = 8'($urandom);
  endtask

  task automatic strobe(input int a, input int b, input int c, input int d, input int comb,
                        input int idle);
    @(negedge clk);
    e0 = 8'(a); e1 = 8'(b); e2 = 8'(c); e3 = 8'(d); ec = 8'(comb);
    valid = 1'b1;
    model_step(a, b, c, d, comb);
    @(negedge clk);
    valid = 1'b0;
    garbage();
    for (int k = 0; k < idle; k++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    valid = 1'($urandom);
    garbage();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    valid = 1'b0;
    model_reset();
  endtask

  function automatic int rnd_err(input int lim);
    if (lim >= 128) return int'($urandom_range(0, 255)) - 128;
    return int'($urandom_range(0, 2 * lim)) - lim;
  endfunction

  initial begin
    int lims [3];
    int lim, mode, cv;
    lims[0] = 12; lims[1] = 40; lims[2] = 128;
    model_reset();

    // reset state
    do_reset();
    check("reset.state", {6'd0, state}, 8'd0);
    check("reset.lock",  {7'd0, lock},  8'd0);
    check("reset.w0", {5'd0, w0}, 8'd1);
    check("reset.w3", {5'd0, w3}, 8'd1);

    // acquisition
    for (int i = 1; i <= 16; i++) begin
      strobe(10, 10, 10, 10, 50, $urandom_range(0, 2));
      if (i == 15) check("acq.pre", {6'd0, state}, 8'd0);
    end
    check("acq.state", {6'd0, state}, 8'd1);
    check("acq.w0", {5'd0, w0}, 8'd5);
    check("acq.w2", {5'd0, w2}, 8'd5);
    check_all("acq");

    // weighting
    for (int i = 0; i < 16; i++) strobe(0, -20, 40, -128, 50, $urandom_range(0, 1));
    check("wgt.w0", {5'd0, w0}, 8'd7);
    check("wgt.w1", {5'd0, w1}, 8'd2);
    check("wgt.w2", {5'd0, w2}, 8'd1);
    check("wgt.w3", {5'd0, w3}, 8'd1);
    check_all("wgt");

    // lock, hold at -16, unlock at -17
    strobe(5, 5, 5, 5, 50, 0);
    for (int i = 1; i <= 32; i++) begin
      strobe(5, 5, 5, 5, 3, $urandom_range(0, 1));
      if (i == 31) check("lock.pre", {7'd0, lock}, 8'd0);
    end
    check("lock.set", {7'd0, lock}, 8'd1);
    strobe(5, 5, 5, 5, -16, 0);
    check("lock.hold16", {7'd0, lock}, 8'd1);
    strobe(5, 5, 5, 5, -17, 0);
    check("unlock.lock",  {7'd0, lock},  8'd0);
    check("unlock.state", {6'd0, state}, 8'd1);
    check_all("lock");

    // loss of acquisition
    for (int i = 0; i < 32; i++) strobe(100, 100, 100, 100, 50, 0);
    check("loss.state", {6'd0, state}, 8'd0);
    check("loss.w1", {5'd0, w1}, 8'd1);
    check_all("loss");

    // mid-window reset
    for (int i = 0; i < 8; i++) strobe(100, -100, 100, -100, 50, 0);
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      strobe(10, 10, 10, 10, 50, 0);
      if (i == 15) check("midrst.pre", {6'd0, state}, 8'd0);
    end
    check("midrst.end", {6'd0, state}, 8'd1);
    check_all("midrst");

    // randomized blocks against the model
    for (int blk = 0; blk < 8; blk++) begin
      lim = lims[$urandom_range(0, 2)];
      mode = $urandom_range(0, 2);
      for (int s = 0; s < 64; s++) begin
        case (mode)
          0: cv = int'($urandom_range(0, 8)) - 4;
          1: cv = int'($urandom_range(0, 40)) - 20;
          default: cv = int'($urandom_range(0, 255)) - 128;
        endcase
        strobe(rnd_err(lim), rnd_err(lim), rnd_err(lim), rnd_err(lim), cv,
               $urandom_range(0, 2));
        check_all("rand");
      end
      if (blk == 4) begin
        do_reset();
        check_all("rand.reset");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/error_weight_controller.md
ERROR_WEIGHT_CONTROLLER -- requirements
Module: error_weight_controller

Interface
REQ-001 SHALL have parameter WINDOW_LOG2, default 4, log2 of samples per weighting window.
REQ-002 SHALL have parameter LOCK_THRESH, default 4, max |error_comb_i| that counts toward lock.
REQ-003 SHALL have parameter LOCK_COUNT, default 32, consecutive in-threshold samples required to declare lock.
REQ-004 SHALL have parameter UNLOCK_THRESH, default 16, |error_comb_i| above which lock is lost.
REQ-005 SHALL have parameter ACQ_THRESH, default 64, window-average |error| at or above which a channel counts as unacquired.
REQ-006 SHALL have port clk_i, input, 1, single clock; all logic on its rising edge.
REQ-007 SHALL have port reset_i, input, 1, synchronous active-high reset.
REQ-008 SHALL have port sample_valid_i, input, 1, one-cycle strobe marking a new error sample set.
REQ-009 SHALL have ports error_0_i..error_3_i, input, 8 each, signed two's-complement per-detector phase error.
REQ-010 SHALL have port error_comb_i, input, 8, signed combined error fed back from the error combiner.
REQ-011 SHALL have ports weight_0_o..weight_3_o, output, 3 each, unsigned weights driving the error combiner.
REQ-012 SHALL have port lock_o, output, 1, high while in LOCKED.
REQ-013 SHALL have port state_o, output, 2, current state encoding.

Function
REQ-014 SHALL implement states ACQUIRE=0, TRACK=1, LOCKED=2; encoding 3 unused, recovers to ACQUIRE on next edge.
REQ-015 SHALL ignore all data inputs on cycles where sample_valid_i is low.
REQ-016 SHALL take |e| as 8-bit unsigned (|-128| = 128) for every error input.
REQ-017 SHALL accumulate |error_n_i| per channel over 2^WINDOW_LOG2 valid samples in (8+WINDOW_LOG2)-bit accumulators, no saturation needed.
REQ-018 SHALL end a window on the edge accepting its final sample; that sample is included; accumulators and window counter restart at zero on the same edge; window counting runs in every state.
REQ-019 SHALL compute per-channel avg = (accumulator incl. final sample) >> WINDOW_LOG2, and weight = max(1, 7 - min(7, avg >> 2)).
REQ-020 SHALL update weight registers at window end only in TRACK (and on the ACQUIRE->TRACK edge); visible the cycle after the final strobe.
REQ-021 SHALL hold all weights at 1 in ACQUIRE and freeze weights in LOCKED.
REQ-022 SHALL transition ACQUIRE->TRACK at the first window end where at least one channel avg < ACQ_THRESH, loading computed weights on that edge.
REQ-023 SHALL transition TRACK->ACQUIRE at a window end where every channel avg >= ACQ_THRESH, setting weights to 1 on that edge.
REQ-024 SHALL, in TRACK, count consecutive valid samples with |error_comb_i| <= LOCK_THRESH, clearing on any valid sample exceeding it; reaching LOCK_COUNT SHALL move to LOCKED on that edge.
REQ-025 SHALL, in LOCKED, return to TRACK on any valid sample with |error_comb_i| > UNLOCK_THRESH, clearing the lock counter.
REQ-026 SHALL give the lock condition priority over the acquisition check when both fire on the same edge.
REQ-027 SHALL drive lock_o registered, equal to (state == LOCKED).

Reset
REQ-028 SHALL, while reset_i is high at a clock edge, set state ACQUIRE, all weights 1, lock_o 0, lock counter, window counter and accumulators 0.
REQ-029 SHALL discard a partial window when reset asserts mid-window; first post-reset window starts with the first valid sample after reset deasserts.

Structure
REQ-030 SHALL place the state enum, 8-bit error width and 3-bit weight width in shared package adpll_pkg.
REQ-031 SHALL use one sub-module abs_accumulator (abs, accumulate, clear-on-window-end, avg output), instantiated four times.

Verification
REQ-032 Reset: assert reset_i 2 cycles -> weights 1,1,1,1, lock_o 0, state_o 0.
REQ-033 Acquisition: e0..e3 = 10,10,10,10 for 16 strobes -> after 16th, state_o 1, weights 5,5,5,5.
REQ-034 Weighting: e0=0, e1=-20, e2=40, e3=-128 for 16 strobes in TRACK -> weights 7,2,1,1.
REQ-035 Lock: TRACK, error_comb_i=3 for 32 strobes -> lock_o 1 after 32nd; one strobe with error_comb_i=-17 -> lock_o 0, state_o 1; -16 alone keeps lock.
REQ-036 Loss: TRACK, all errors 100 for 16 strobes -> state_o 0, weights 1,1,1,1.
REQ-037 Mid-window reset: 8 strobes, reset, then 16 strobes of 10 -> window end occurs on the 16th post-reset strobe exactly.
